// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and constants for the AXI-Stream packet FIFO.
package axis_fifo_pkg;

  localparam int MODE_CUT = 0;
  localparam int MODE_SAF = 1;

  typedef enum logic [0:0] {
    BYP_IDLE   = 1'b0,
    BYP_ACTIVE = 1'b1
  } byp_state_e;

  // Counts must reach FIFO_DEPTH itself, hence one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle (data, keep, last, valid, ready) with source/sink views.
interface axis_pkt_fifo_if #(
  parameter int TDATA_WIDTH = 512
) ();

  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port storage for {tlast, tkeep, tdata}; one write port, one registered read port.
module axis_fifo_ram #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read register doubles as the first-word-fall-through output stage.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO with TKEEP/TLAST, optional store-and-forward,
// packet counter, programmable almost-full and a sticky oversize-packet flag.
module axis_pkt_fifo
  import axis_fifo_pkg::*;
#(
  parameter int  TDATA_WIDTH   = 512,
  parameter int  FIFO_DEPTH    = 512,
  parameter int  PACKET_MODE   = MODE_CUT,
  parameter int  PROG_FULL_THR = 448,
  localparam int CW            = count_width(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  axis_pkt_fifo_if.slave  s_axis,
  axis_pkt_fifo_if.master m_axis,
  output logic [CW-1:0]   wr_data_count,
  output logic [CW-1:0]   pkt_count,
  output logic            prog_full,
  output logic            oversize_pkt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = TDATA_WIDTH / 8;
  localparam int RW = TDATA_WIDTH + KW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THR_C   = CW'(PROG_FULL_THR);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic          tready_q, tready_d;
  logic          prog_full_q, prog_full_d;
  logic          oversize_q;
  byp_state_e    byp_q;

  logic                   wr_fire;
  logic                   rd_fire;
  logic                   wr_last;
  logic                   rd_last;
  logic                   ram_re;
  logic                   eligible;
  logic                   m_valid;
  logic [RW-1:0]          ram_wdata;
  logic [RW-1:0]          ram_rdata;
  logic [TDATA_WIDTH-1:0] out_data;
  logic [KW-1:0]          out_keep;
  logic                   out_last;

  assign ram_wdata = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
  assign out_data  = ram_rdata[TDATA_WIDTH-1:0];
  assign out_keep  = ram_rdata[TDATA_WIDTH +: KW];
  assign out_last  = ram_rdata[RW-1];

  // In store-and-forward the head beat is held until a whole packet is
  // present, unless an oversize packet has forced a cut-through bypass.
  assign eligible = (PACKET_MODE == MODE_CUT) || (pkt_cnt_q != '0) || (byp_q == BYP_ACTIVE);
  assign m_valid  = out_valid_q && eligible;
  assign wr_fire  = s_axis.tvalid && tready_q;
  assign rd_fire  = m_valid && m_axis.tready;
  assign wr_last  = wr_fire && s_axis.tlast;
  assign rd_last  = rd_fire && out_last;

  // Prefetch the next stored beat whenever the output stage is empty or being consumed.
  assign ram_re = (ram_cnt_q != '0) && (!out_valid_q || rd_fire);

  axis_fifo_ram #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ram_cnt_d   = ram_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    out_valid_d = out_valid_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (ram_re) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // ram_cnt tracks beats not yet moved into the output stage.
    case ({wr_fire, ram_re})
      2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase

    case ({wr_last, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    if (ram_re) begin
      out_valid_d = 1'b1;
    end else if (rd_fire) begin
      out_valid_d = 1'b0;
    end

    tready_d    = (count_d != DEPTH_C);
    prog_full_d = (count_d >= THR_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ram_cnt_q   <= '0;
      pkt_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      tready_q    <= 1'b0;
      prog_full_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ram_cnt_q   <= ram_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      out_valid_q <= out_valid_d;
      tready_q    <= tready_d;
      prog_full_q <= prog_full_d;
    end
  end

  // A full FIFO with no complete packet can never drain in store-and-forward,
  // so the current packet is released as cut-through until its TLAST leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q      <= BYP_IDLE;
      oversize_q <= 1'b0;
    end else begin
      case (byp_q)
        BYP_IDLE: begin
          if ((PACKET_MODE == MODE_SAF) && (count_q == DEPTH_C) && (pkt_cnt_q == '0)) begin
            byp_q      <= BYP_ACTIVE;
            oversize_q <= 1'b1;
          end
        end
        BYP_ACTIVE: begin
          if (rd_last) begin
            byp_q <= BYP_IDLE;
          end
        end
        default: byp_q <= BYP_IDLE;
      endcase
    end
  end

  // The RAM read register carries no reset, so payload is gated by the stage valid.
  assign m_axis.tdata  = out_valid_q ? out_data : '0;
  assign m_axis.tkeep  = out_valid_q ? out_keep : '0;
  assign m_axis.tlast  = out_valid_q && out_last;
  assign m_axis.tvalid = m_valid;
  assign s_axis.tready = tready_q;

  assign wr_data_count = count_q;
  assign pkt_count     = pkt_cnt_q;
  assign prog_full     = prog_full_q;
  assign oversize_pkt  = oversize_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: instance 0 is cut-through, instance 1 store-and-forward.
module tb_axis_pkt_fifo;

  logic clk;
  logic rst_n;

  logic [31:0] s_data  [2];
  logic [3:0]  s_keep  [2];
  logic        s_last  [2];
  logic        s_valid [2];
  logic        m_ready [2];

  logic        s_ready [2];
  logic        m_valid [2];
  logic        m_last  [2];
  logic [31:0] m_data  [2];
  logic [3:0]  m_keep  [2];
  logic [4:0]  cnt     [2];
  logic [4:0]  pktc    [2];
  logic        pf      [2];
  logic        ovs     [2];

  int vectors = 0;
  int errors  = 0;
  int cnt_m [2];
  int pkt_m [2];
  logic [36:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    axis_pkt_fifo_if #(.TDATA_WIDTH(32)) s_if ();
    axis_pkt_fifo_if #(.TDATA_WIDTH(32)) m_if ();
    logic [4:0] cnt_w;
    logic [4:0] pkt_w;
    logic       pf_w;
    logic       ovs_w;

    assign s_if.tdata  = s_data[gi];
    assign s_if.tkeep  = s_keep[gi];
    assign s_if.tlast  = s_last[gi];
    assign s_if.tvalid = s_valid[gi];
    assign m_if.tready = m_ready[gi];
    assign s_ready[gi] = s_if.tready;
    assign m_valid[gi] = m_if.tvalid;
    assign m_last[gi]  = m_if.tlast;
    assign m_data[gi]  = m_if.tdata;
    assign m_keep[gi]  = m_if.tkeep;
    assign cnt[gi]     = cnt_w;
    assign pktc[gi]    = pkt_w;
    assign pf[gi]      = pf_w;
    assign ovs[gi]     = ovs_w;

    axis_pkt_fifo #(
      .TDATA_WIDTH   (32),
      .FIFO_DEPTH    (16),
      .PACKET_MODE   (gi),
      .PROG_FULL_THR (12)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .wr_data_count (cnt_w),
      .pkt_count     (pkt_w),
      .prog_full     (pf_w),
      .oversize_pkt  (ovs_w)
    );
  end

  function automatic logic [36:0] mk(input logic last, input logic [3:0] keep, input logic [31:0] data);
    return {last, keep, data};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock of traffic on DUT d, scored against the reference queue and counters.
  task automatic step(input int d, input bit sv, input bit mr, input logic [36:0] beat, output bit wf);
    bit rf;
    logic [36:0] exp_beat;
    s_valid[d] = sv;
    s_data[d]  = beat[31:0];
    s_keep[d]  = beat[35:32];
    s_last[d]  = beat[36];
    m_ready[d] = mr;
    wf = sv && s_ready[d];
    rf = mr && m_valid[d];
    if (rf) begin
      if (sb.size() == 0) begin
        check("rd_when_model_empty", 64'(m_valid[d]), 64'd0);
      end else begin
        exp_beat = sb.pop_front();
        check("rd_beat", 64'({m_last[d], m_keep[d], m_data[d]}), 64'(exp_beat));
        if (exp_beat[36]) pkt_m[d]--;
      end
      cnt_m[d]--;
    end
    if (wf) begin
      sb.push_back(beat);
      cnt_m[d]++;
      if (beat[36]) pkt_m[d]++;
    end
    tick();
    s_valid[d] = 1'b0;
    m_ready[d] = 1'b0;
    check("count", 64'(cnt[d]), 64'(cnt_m[d]));
    check("pkt_count", 64'(pktc[d]), 64'(pkt_m[d]));
    check("prog_full", 64'(pf[d]), 64'(cnt_m[d] >= 12));
    check("s_ready", 64'(s_ready[d]), 64'(cnt_m[d] != 16));
  endtask

  task automatic drain(input int d);
    bit wf;
    for (int k = 0; k < 64 && sb.size() != 0; k++) step(d, 1'b0, 1'b1, '0, wf);
    check("drain_left", 64'(sb.size()), 64'd0);
    check("drain_valid", 64'(m_valid[d]), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit wf;
    int idx;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      s_data[d] = '0; s_keep[d] = '0; s_last[d] = 1'b0; s_valid[d] = 1'b0; m_ready[d] = 1'b0;
      cnt_m[d] = 0; pkt_m[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset state and release
    for (int d = 0; d < 2; d++) begin
      check("rst_s_ready", 64'(s_ready[d]), 64'd0);
      check("rst_m_valid", 64'(m_valid[d]), 64'd0);
      check("rst_count", 64'(cnt[d]), 64'd0);
      check("rst_pkt", 64'(pktc[d]), 64'd0);
      check("rst_pf", 64'(pf[d]), 64'd0);
      check("rst_ovs", 64'(ovs[d]), 64'd0);
      check("rst_m_data", 64'(m_data[d]), 64'd0);
    end
    #2 rst_n = 1'b1;
    check("rel_ready_first_cycle", 64'(s_ready[0]), 64'd0);
    tick();
    check("rel_ready_ct", 64'(s_ready[0]), 64'd1);
    check("rel_ready_saf", 64'(s_ready[1]), 64'd1);

    // Empty FIFO latency: written at edge N, visible after N+1
    step(0, 1'b1, 1'b1, mk(1'b1, 4'hF, 32'h6000_0001), wf);
    check("t6_valid_edge_n", 64'(m_valid[0]), 64'd0);
    step(0, 1'b0, 1'b1, '0, wf);
    check("t6_valid_edge_n1", 64'(m_valid[0]), 64'd1);
    check("t6_data", 64'(m_data[0]), 64'h6000_0001);
    step(0, 1'b0, 1'b1, '0, wf);
    step(0, 1'b0, 1'b1, '0, wf);
    check("t6_valid_empty", 64'(m_valid[0]), 64'd0);

    // Fill to full, stall, read-while-full, drain
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b1, 1'b0, mk(i % 4 == 3, 4'(i + 1), 32'hA100_0000 + 32'(i)), wf);
    end
    check("t1_full_count", 64'(cnt[0]), 64'd16);
    check("t1_full_ready", 64'(s_ready[0]), 64'd0);
    check("t1_prog_full", 64'(pf[0]), 64'd1);
    check("t1_head", 64'({m_last[0], m_keep[0], m_data[0]}), 64'(mk(1'b0, 4'h1, 32'hA100_0000)));
    step(0, 1'b0, 1'b0, '0, wf);
    check("t1_stall_stable", 64'({m_last[0], m_keep[0], m_data[0]}), 64'(mk(1'b0, 4'h1, 32'hA100_0000)));
    step(0, 1'b1, 1'b1, mk(1'b0, 4'h0, 32'h0000_DEAD), wf);
    check("t1_full_rw_count", 64'(cnt[0]), 64'd15);
    drain(0);

    // Random concurrent traffic, then both sides always ready
    idx = 0;
    for (int k = 0; k < 1000; k++) begin
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           mk($urandom_range(0, 3) == 0, 4'($urandom), 32'hB000_0000 + 32'(idx)), wf);
      if (wf) idx++;
    end
    drain(0);
    for (int k = 0; k < 60; k++) begin
      step(0, 1'b1, 1'b1, mk(k % 5 == 4, 4'hF, 32'hC000_0000 + 32'(k)), wf);
      if (k >= 1) check("t2_thru_valid", 64'(m_valid[0]), 64'd1);
    end
    drain(0);

    // Store-and-forward: 3-beat packet held until TLAST
    step(1, 1'b1, 1'b1, mk(1'b0, 4'hF, 32'hD000_0000), wf);
    check("t3_hold0", 64'(m_valid[1]), 64'd0);
    step(1, 1'b1, 1'b1, mk(1'b0, 4'h3, 32'hD000_0001), wf);
    check("t3_hold1", 64'(m_valid[1]), 64'd0);
    step(1, 1'b1, 1'b1, mk(1'b1, 4'h1, 32'hD000_0002), wf);
    check("t3_pkt_after_last", 64'(pktc[1]), 64'd1);
    step(1, 1'b0, 1'b1, '0, wf);
    check("t3_valid_after_last", 64'(m_valid[1]), 64'd1);
    drain(1);

    // Complete packet followed by a partial one
    step(1, 1'b1, 1'b0, mk(1'b0, 4'h7, 32'hD100_0000), wf);
    step(1, 1'b1, 1'b0, mk(1'b1, 4'h7, 32'hD100_0001), wf);
    step(1, 1'b1, 1'b0, mk(1'b0, 4'h5, 32'hD200_0000), wf);
    step(1, 1'b1, 1'b0, mk(1'b0, 4'h5, 32'hD200_0001), wf);
    for (int k = 0; k < 4; k++) step(1, 1'b0, 1'b1, '0, wf);
    check("saf_partial_hold", 64'(m_valid[1]), 64'd0);
    step(1, 1'b1, 1'b1, mk(1'b1, 4'h5, 32'hD200_0002), wf);
    drain(1);

    // Oversize packet forces bypass
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      step(1, 1'b1, 1'b0, mk(idx == 19, 4'(idx), 32'hE000_0000 + 32'(idx)), wf);
      if (wf) idx++;
    end
    check("t4_full_count", 64'(cnt[1]), 64'd16);
    check("t4_ovs_before", 64'(ovs[1]), 64'd0);
    check("t4_valid_before", 64'(m_valid[1]), 64'd0);
    step(1, 1'b0, 1'b0, '0, wf);
    check("t4_ovs_set", 64'(ovs[1]), 64'd1);
    check("t4_bypass_valid", 64'(m_valid[1]), 64'd1);
    for (int k = 0; k < 80 && (idx < 20 || sb.size() != 0); k++) begin
      step(1, idx < 20, 1'b1, mk(idx == 19, 4'(idx), 32'hE000_0000 + 32'(idx)), wf);
      if (wf) idx++;
    end
    check("t4_all_written", 64'(idx), 64'd20);
    check("t4_all_read", 64'(sb.size()), 64'd0);
    check("t4_ovs_sticky", 64'(ovs[1]), 64'd1);
    step(1, 1'b1, 1'b1, mk(1'b0, 4'hA, 32'hE100_0000), wf);
    step(1, 1'b0, 1'b1, '0, wf);
    check("t4_fsm_idle_gate", 64'(m_valid[1]), 64'd0);
    step(1, 1'b1, 1'b1, mk(1'b1, 4'hA, 32'hE100_0001), wf);
    drain(1);
    check("t4_ovs_still", 64'(ovs[1]), 64'd1);

    // Reset in the middle of a packet
    for (int k = 0; k < 5; k++) step(1, 1'b1, 1'b0, mk(1'b0, 4'hC, 32'hF000_0000 + 32'(k)), wf);
    rst_n = 1'b0;
    #1;
    check("t5_count", 64'(cnt[1]), 64'd0);
    check("t5_m_valid", 64'(m_valid[1]), 64'd0);
    check("t5_s_ready", 64'(s_ready[1]), 64'd0);
    check("t5_pf", 64'(pf[1]), 64'd0);
    check("t5_ovs", 64'(ovs[1]), 64'd0);
    check("t5_m_data", 64'(m_data[1]), 64'd0);
    sb.delete();
    for (int d = 0; d < 2; d++) begin
      cnt_m[d] = 0;
      pkt_m[d] = 0;
    end
    tick();
    tick();
    #3 rst_n = 1'b1;
    check("t5_ready_first_cycle", 64'(s_ready[1]), 64'd0);
    tick();
    check("t5_ready_after", 64'(s_ready[1]), 64'd1);
    check("t5_count_after", 64'(cnt[1]), 64'd0);
    check("t5_valid_after", 64'(m_valid[1]), 64'd0);
    step(1, 1'b1, 1'b1, mk(1'b0, 4'h9, 32'hF100_0000), wf);
    step(1, 1'b1, 1'b1, mk(1'b1, 4'h9, 32'hF100_0001), wf);
    drain(1);

    check("ct_never_oversize", 64'(ovs[0]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
